// File: rtl/switch_cpu_pkg.sv
// Shared opcode constants and FSM state encoding
// for the switch-driven accumulator core.
package switch_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_CLR  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sw_sync.sv
// Two-flop synchronizer bringing the raw switch
// levels into the clock domain.
module sw_sync #(
    parameter int NUM_SW = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NUM_SW-1:0] d,
    output logic [NUM_SW-1:0] q
);

    logic [NUM_SW-1:0] meta_q;
    logic [NUM_SW-1:0] sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/switch_cpu_core.sv
// Accumulator core: single-cycle ALU ops plus a
// shift-add multiplier, operand B from the switches.
module switch_cpu_core
    import switch_cpu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_SW = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NUM_SW-1:0] sw,
    input  logic [3:0]        operation,
    input  logic              enable,
    output logic [WIDTH-1:0]  out,
    output logic              valid,
    output logic              busy,
    output logic              zero,
    output logic              carry
);

    localparam int CW = $clog2(WIDTH);

    logic [NUM_SW-1:0]  sw_s;
    logic [WIDTH-1:0]   b;
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [WIDTH:0]     ext;

    sw_sync #(.NUM_SW(NUM_SW)) u_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (sw),
        .q      (sw_s)
    );

    assign b = WIDTH'(sw_s);

    always_comb begin
        alu_res = acc_q;
        alu_c   = 1'b0;
        ext     = '0;
        unique case (operation)
            OP_LOAD: alu_res = b;
            OP_ADD: begin
                ext     = {1'b0, acc_q} + {1'b0, b};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_SUB: begin
                ext     = {1'b0, acc_q} - {1'b0, b};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_AND: alu_res = acc_q & b;
            OP_OR:  alu_res = acc_q | b;
            OP_XOR: alu_res = acc_q ^ b;
            OP_NOT: alu_res = ~acc_q;
            OP_SHL: begin
                alu_res = acc_q << 1;
                alu_c   = acc_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = acc_q >> 1;
                alu_c   = acc_q[0];
            end
            OP_CLR: alu_res = '0;
            default: ;
        endcase
    end

    assign sum = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    if (operation == OP_MUL) begin
                        state_d  = S_MUL;
                        cnt_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, acc_q};
                        mplier_d = b;
                        prod_d   = '0;
                    end else begin
                        state_d = S_DONE;
                        acc_d   = alu_res;
                        carry_d = alu_c;
                        zero_d  = (alu_res == '0);
                    end
                end
            end
            S_MUL: begin
                prod_d   = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Last multiplier bit: commit low half, flag lost high bits
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    acc_d   = sum[WIDTH-1:0];
                    carry_d = |sum[2*WIDTH-1:WIDTH];
                    zero_d  = (sum[WIDTH-1:0] == '0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign out   = acc_q;
    assign valid = (state_q == S_DONE);
    assign busy  = (state_q == S_MUL);
    assign zero  = zero_q;
    assign carry = carry_q;

endmodule
